// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus bundle: per-port result pushes from the execution
// unit, the merged writeback port toward the reorder buffer, and the
// flush/stall controls. The slave modport is the arbiter's view; the master
// modport is the execution-unit / ROB side that drives it.
interface writeback_arbiter_if #(
    parameter int PORTS  = 3,
    parameter int DATA_W = 32,
    parameter int PKT_W  = 16
);
    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic                              flush_i;
    logic                              stall_i;
    logic [PORTS-1:0][DATA_W-1:0]      result_i;
    logic [PORTS-1:0][PKT_W-1:0]       ipacket_i;
    logic [PORTS-1:0]                  valid_i;
    logic [PORTS-1:0]                  full_o;
    logic [DATA_W-1:0]                 result_o;
    logic [PKT_W-1:0]                  ipacket_o;
    logic                              valid_o;
    logic [GW-1:0]                     grant_port_o;
    logic                              overflow_o;

    modport slave (
        input  flush_i, stall_i, result_i, ipacket_i, valid_i,
        output full_o, result_o, ipacket_o, valid_o, grant_port_o, overflow_o
    );

    modport master (
        output flush_i, stall_i, result_i, ipacket_i, valid_i,
        input  full_o, result_o, ipacket_o, valid_o, grant_port_o, overflow_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one small circular FIFO per result port, a round-robin
// grant of one queue head per cycle into a registered writeback port, per-port
// full flags for issue backpressure and a sticky overflow flag.
// Optional macro WB_BYPASS_EN: an empty port pushing this cycle competes in
// the round robin and, when it wins, its input goes straight to the output
// registers (1-cycle push-to-output instead of 2).
// flush_i is the synchronous clear; rst_n_i is the asynchronous reset.
module writeback_arbiter #(
    parameter int PORTS  = 3,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int PKT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    writeback_arbiter_if.slave   wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // queue storage and bookkeeping
    logic [DATA_W-1:0] q_data_r [PORTS][DEPTH];
    logic [PKT_W-1:0]  q_pkt_r  [PORTS][DEPTH];
    logic [PW-1:0]     wr_ptr_r [PORTS];
    logic [PW-1:0]     rd_ptr_r [PORTS];
    logic [CW-1:0]     count_r  [PORTS];
    logic [CW-1:0]     count_nxt_s [PORTS];
    logic [PORTS-1:0]  full_r;

    // arbitration
    logic [GW-1:0]     rr_ptr_r;
    logic [PORTS-1:0]  req_s;
    logic [PORTS-1:0]  byp_s;
    logic              arb_en_s;
    logic              found_s;
    logic              grant_s;
    logic [GW-1:0]     win_s;
    logic [GW-1:0]     rr_nxt_s;

    // per-port actions this cycle
    logic [PORTS-1:0]  pop_s;
    logic [PORTS-1:0]  take_byp_s;
    logic [PORTS-1:0]  push_ok_s;
    logic [PORTS-1:0]  full_now_s;
    logic              ovf_set_s;

    // output registers
    logic [DATA_W-1:0] out_data_s;
    logic [PKT_W-1:0]  out_pkt_s;
    logic [DATA_W-1:0] result_r;
    logic [PKT_W-1:0]  ipacket_r;
    logic              valid_r;
    logic [GW-1:0]     grant_r;
    logic              overflow_r;

    assign arb_en_s = !wb.flush_i && !wb.stall_i;
    assign grant_s  = arb_en_s && found_s;
    assign rr_nxt_s = (win_s == GW'(PORTS - 1)) ? {GW{1'b0}} : (win_s + GW'(1));

    // Request vector: non-empty queues, plus empty ports pushing now when bypass is built in
    always_comb begin
        req_s = {PORTS{1'b0}};
        byp_s = {PORTS{1'b0}};
        for (int k = 0; k < PORTS; k++) begin
`ifdef WB_BYPASS_EN
            byp_s[k] = (count_r[k] == {CW{1'b0}}) && wb.valid_i[k];
`else
            byp_s[k] = 1'b0;
`endif
            req_s[k] = (count_r[k] != {CW{1'b0}}) || byp_s[k];
        end
    end

    // Round-robin search starting at the RR pointer; first requester wins
    always_comb begin
        int idx;
        found_s = 1'b0;
        win_s   = {GW{1'b0}};
        idx     = 0;
        for (int i = 0; i < PORTS; i++) begin
            idx = (int'(rr_ptr_r) + i) % PORTS;
            if (!found_s && req_s[idx]) begin
                found_s = 1'b1;
                win_s   = GW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Per-port pop / bypass / push acceptance / overflow and next count
    always_comb begin
        pop_s      = {PORTS{1'b0}};
        take_byp_s = {PORTS{1'b0}};
        push_ok_s  = {PORTS{1'b0}};
        full_now_s = {PORTS{1'b0}};
        ovf_set_s  = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            count_nxt_s[k] = count_r[k];
            full_now_s[k]  = (count_r[k] == DEPTH_C);
            if (grant_s && (win_s == GW'(k))) begin
                pop_s[k]      = !byp_s[k];
                take_byp_s[k] = byp_s[k];
            end else begin
                pop_s[k]      = 1'b0;
                take_byp_s[k] = 1'b0;
            end
            // a pop in the same cycle frees the slot a full-queue push needs
            push_ok_s[k] = wb.valid_i[k] && !wb.flush_i && !take_byp_s[k]
                           && (!full_now_s[k] || pop_s[k]);
            if (wb.valid_i[k] && !wb.flush_i && full_now_s[k] && !pop_s[k]) begin
                ovf_set_s = 1'b1;
            end else begin
                ovf_set_s = ovf_set_s;
            end
            count_nxt_s[k] = count_r[k] + CW'(push_ok_s[k]) - CW'(pop_s[k]);
        end
    end

    // Data to load into the output registers: winner's queue head or its live input
    always_comb begin
        out_data_s = {DATA_W{1'b0}};
        out_pkt_s  = {PKT_W{1'b0}};
        for (int k = 0; k < PORTS; k++) begin
            if (win_s == GW'(k)) begin
                if (byp_s[k]) begin
                    out_data_s = wb.result_i[k];
                    out_pkt_s  = wb.ipacket_i[k];
                end else begin
                    out_data_s = q_data_r[k][rd_ptr_r[k]];
                    out_pkt_s  = q_pkt_r[k][rd_ptr_r[k]];
                end
            end else begin
                out_data_s = out_data_s;
                out_pkt_s  = out_pkt_s;
            end
        end
    end

    // Queue payload RAM: written at the write pointer on accepted pushes only
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < PORTS; k++) begin
            if (push_ok_s[k]) begin
                q_data_r[k][wr_ptr_r[k]] <= wb.result_i[k];
                q_pkt_r[k][wr_ptr_r[k]]  <= wb.ipacket_i[k];
            end
        end
    end

    // Queue pointers, counts and registered full flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < PORTS; k++) begin
                wr_ptr_r[k] <= {PW{1'b0}};
                rd_ptr_r[k] <= {PW{1'b0}};
                count_r[k]  <= {CW{1'b0}};
            end
            full_r <= {PORTS{1'b0}};
        end else if (wb.flush_i) begin
            for (int k = 0; k < PORTS; k++) begin
                wr_ptr_r[k] <= {PW{1'b0}};
                rd_ptr_r[k] <= {PW{1'b0}};
                count_r[k]  <= {CW{1'b0}};
            end
            full_r <= {PORTS{1'b0}};
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                if (push_ok_s[k]) begin
                    wr_ptr_r[k] <= wr_ptr_r[k] + PW'(1);
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k] <= rd_ptr_r[k] + PW'(1);
                end
                count_r[k] <= count_nxt_s[k];
                full_r[k]  <= (count_nxt_s[k] == DEPTH_C);
            end
        end
    end

    // Output register and RR pointer: load on grant, drop valid when idle, hold on stall
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_r  <= {DATA_W{1'b0}};
            ipacket_r <= {PKT_W{1'b0}};
            valid_r   <= 1'b0;
            grant_r   <= {GW{1'b0}};
            rr_ptr_r  <= {GW{1'b0}};
        end else if (wb.flush_i) begin
            valid_r  <= 1'b0;
            rr_ptr_r <= {GW{1'b0}};
        end else if (arb_en_s) begin
            if (found_s) begin
                result_r  <= out_data_s;
                ipacket_r <= out_pkt_s;
                valid_r   <= 1'b1;
                grant_r   <= win_s;
                rr_ptr_r  <= rr_nxt_s;
            end else begin
                valid_r <= 1'b0;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky overflow: survives flush, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign wb.full_o       = full_r;
    assign wb.result_o     = result_r;
    assign wb.ipacket_o    = ipacket_r;
    assign wb.valid_o      = valid_r;
    assign wb.grant_port_o = grant_r;
    assign wb.overflow_o   = overflow_r;
endmodule
